nibble_alu: RTL

NIBBLE_ALU -- requirements
Module: nibble_alu

---
 rtl/nibble_alu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/nibble_alu.sv
// nibble_alu: nibble-serial operand loader feeding an add/sub/mul/mac unit,
// with the result streamed out least-significant byte first under valid/ready.
module nibble_alu #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ACC_EN = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);
    localparam int unsigned Beats = WIDTH / 4;
    localparam int unsigned BeatW = $clog2(Beats);
    localparam int unsigned AccW  = 2 * WIDTH;
    localparam int unsigned Bytes = AccW / 8;
    localparam int unsigned ByteW = $clog2(Bytes);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [ByteW-1:0] LastHalf = ByteW'(WIDTH / 8 - 1);
    localparam logic [ByteW-1:0] LastFull = ByteW'(Bytes - 1);

    typedef enum logic [1:0] {StLoad, StExec, StSend} state_e;

    state_e            state_q, state_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [AccW-1:0]   res_q, res_d;
    logic              flag_q, flag_d;
    logic [ByteW-1:0]  idx_q, idx_d;
    logic [ByteW-1:0]  last_q, last_d;

    logic [3:0] a_nib, b_nib;
    logic [1:0] op_in;
    logic       in_valid, out_ready;
    logic       beat_fire, final_beat, byte_fire, final_byte;

    assign a_nib     = io_in[3:0];
    assign b_nib     = io_in[7:4];
    assign op_in     = io_in[9:8];
    assign in_valid  = io_in[10];
    assign out_ready = io_in[11];

    assign beat_fire  = (state_q == StLoad) && in_valid;
    assign final_beat = beat_fire && (beat_q == LastBeat);
    assign byte_fire  = (state_q == StSend) && out_ready;
    assign final_byte = byte_fire && (idx_q == last_q);

    logic [WIDTH:0]  add_sum, sub_diff;
    logic [AccW-1:0] prod;
    logic [AccW:0]   mac_sum;

    always_comb begin
        add_sum  = {1'b0, a_q} + {1'b0, b_q};
        sub_diff = {1'b0, a_q} - {1'b0, b_q};
        prod     = AccW'(a_q) * AccW'(b_q);
        mac_sum  = {1'b0, acc_q} + {1'b0, prod};
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StLoad:  if (final_beat) state_d = StExec;
            StExec:  state_d = StSend;
            StSend:  if (final_byte) state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    // Datapath next-state
    always_comb begin
        beat_d = beat_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        acc_d  = acc_q;
        res_d  = res_q;
        flag_d = flag_q;
        idx_d  = idx_q;
        last_d = last_q;
        case (state_q)
            StLoad: begin
                if (beat_fire) begin
                    a_d[{beat_q, 2'b00} +: 4] = a_nib;
                    b_d[{beat_q, 2'b00} +: 4] = b_nib;
                    beat_d = final_beat ? '0 : beat_q + BeatW'(1);
                    if (final_beat) op_d = op_in;
                end
            end
            StExec: begin
                idx_d = '0;
                case (op_q)
                    2'b00: begin
                        res_d  = AccW'(add_sum[WIDTH-1:0]);
                        flag_d = add_sum[WIDTH];
                        last_d = LastHalf;
                    end
                    2'b01: begin
                        res_d  = AccW'(sub_diff[WIDTH-1:0]);
                        flag_d = sub_diff[WIDTH];
                        last_d = LastHalf;
                    end
                    default: begin
                        res_d  = prod;
                        flag_d = 1'b0;
                        last_d = LastFull;
                        if (op_q == 2'b11 && ACC_EN != 0) begin
                            acc_d  = mac_sum[AccW-1:0];
                            res_d  = mac_sum[AccW-1:0];
                            flag_d = mac_sum[AccW];
                        end
                    end
                endcase
            end
            StSend: begin
                if (byte_fire) begin
                    idx_d = final_byte ? '0 : idx_q + ByteW'(1);
                    if (final_byte) flag_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            flag_q <= 1'b0;
            idx_q  <= '0;
            last_q <= '0;
        end else begin
            beat_q <= beat_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            flag_q <= flag_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    // Outputs decode from registers only; flag and byte are masked outside SEND
    always_comb begin
        io_out     = '0;
        io_out[10] = (state_q == StLoad);
        if (state_q == StSend) begin
            io_out[7:0] = res_q[{idx_q, 3'b000} +: 8];
            io_out[8]   = 1'b1;
            io_out[9]   = (idx_q == last_q);
            io_out[11]  = flag_q;
        end
    end

endmodule
